// File: rtl/knn_mem_pkg.sv
// Shared types and default sizes for the kNN local buffer and its arbiter.
// The round-robin grant rule lives here so both the arbiter and any future users agree on it.
package knn_mem_pkg;

  localparam int KNN_MEM_DW    = 256;
  localparam int KNN_MEM_AW    = 11;
  localparam int KNN_MEM_RDLAT = 1;

  typedef struct packed {
    logic                  we;
    logic [KNN_MEM_AW-1:0] addr;
    logic [KNN_MEM_DW-1:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_tag_t;

  // One-hot grant for two requesters; ptr names the favoured one on a conflict.
  function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic ptr);
    logic [1:0] g;
    g = 2'b00;
    if (req[0] && (!req[1] || !ptr)) begin
      g = 2'b01;
    end else if (req[1]) begin
      g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/knn_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer register steered away
// from whoever was just granted.
module knn_rr_arb2
  import knn_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_reg;
  logic ptr_next;

  always_comb begin
    gnt      = rr_grant(req, ptr_reg);
    ptr_next = ptr_reg;
    if (gnt[0]) begin
      ptr_next = 1'b1;
    end else if (gnt[1]) begin
      ptr_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/knn_local_mem_arbiter.sv
// Shares one single-port local buffer between the tile loader (r0) and the distance
// engine (r1); read data comes straight from q0, qualified by a tag pipeline.
module knn_local_mem_arbiter
  import knn_mem_pkg::*;
#(
  parameter int DataWidth    = KNN_MEM_DW,
  parameter int AddressWidth = KNN_MEM_AW,
  parameter int RdLatency    = KNN_MEM_RDLAT
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    r0_req_valid,
  output logic                    r0_req_ready,
  input  logic                    r0_req_we,
  input  logic [AddressWidth-1:0] r0_req_addr,
  input  logic [DataWidth-1:0]    r0_req_wdata,
  output logic                    r0_rsp_valid,
  output logic [DataWidth-1:0]    r0_rsp_data,

  input  logic                    r1_req_valid,
  output logic                    r1_req_ready,
  input  logic                    r1_req_we,
  input  logic [AddressWidth-1:0] r1_req_addr,
  input  logic [DataWidth-1:0]    r1_req_wdata,
  output logic                    r1_rsp_valid,
  output logic [DataWidth-1:0]    r1_rsp_data,

  output logic [AddressWidth-1:0] mem_address0,
  output logic                    mem_ce0,
  output logic                    mem_we0,
  output logic [DataWidth-1:0]    mem_d0,
  input  logic [DataWidth-1:0]    mem_q0
);

  logic [1:0]              req;
  logic [1:0]              gnt;
  logic                    xfer;
  logic                    sel_id;
  logic                    sel_we;
  logic [AddressWidth-1:0] sel_addr;
  logic [DataWidth-1:0]    sel_wdata;

  assign req = {r1_req_valid, r0_req_valid};

  knn_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  // Grant is purely combinational, so mask ready while reset holds the datapath.
  assign r0_req_ready = gnt[0] & reset;
  assign r1_req_ready = gnt[1] & reset;

  assign xfer   = |gnt;
  assign sel_id = gnt[1];

  always_comb begin
    sel_we    = r0_req_we;
    sel_addr  = r0_req_addr;
    sel_wdata = r0_req_wdata;
    if (sel_id) begin
      sel_we    = r1_req_we;
      sel_addr  = r1_req_addr;
      sel_wdata = r1_req_wdata;
    end
  end

  // Command stage: address/data only move on a transfer, idle cycles just drop ce/we.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ce0      <= 1'b0;
      mem_we0      <= 1'b0;
      mem_address0 <= '0;
      mem_d0       <= '0;
    end else if (xfer) begin
      mem_ce0      <= 1'b1;
      mem_we0      <= sel_we;
      mem_address0 <= sel_addr;
      mem_d0       <= sel_wdata;
    end else begin
      mem_ce0      <= 1'b0;
      mem_we0      <= 1'b0;
    end
  end

  // Tag pipeline: stage 0 aligns with the command register, the last stage with q0.
  rsp_tag_t tag_reg [RdLatency+1];
  rsp_tag_t tag_next;

  always_comb begin
    tag_next.valid = xfer & ~sel_we;
    tag_next.id    = sel_id;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_reg[0] <= '0;
    end else begin
      tag_reg[0] <= tag_next;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= RdLatency; gi++) begin : g_tag
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tag_reg[gi] <= '0;
        end else begin
          tag_reg[gi] <= tag_reg[gi-1];
        end
      end
    end
  endgenerate

  assign r0_rsp_valid = tag_reg[RdLatency].valid & ~tag_reg[RdLatency].id;
  assign r1_rsp_valid = tag_reg[RdLatency].valid &  tag_reg[RdLatency].id;
  assign r0_rsp_data  = mem_q0;
  assign r1_rsp_data  = mem_q0;

endmodule

// File: tb/tb_knn_local_mem_arbiter.sv
// Directed bench for knn_local_mem_arbiter: one instance at RdLatency=1 and one at
// RdLatency=3, each attached to a behavioural single-port buffer.
module tb_knn_local_mem_arbiter;

  localparam int DW = 256;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A (RdLatency=1)
  logic          r0_req_valid, r0_req_ready, r0_req_we, r0_rsp_valid;
  logic [AW-1:0] r0_req_addr;
  logic [DW-1:0] r0_req_wdata, r0_rsp_data;
  logic          r1_req_valid, r1_req_ready, r1_req_we, r1_rsp_valid;
  logic [AW-1:0] r1_req_addr;
  logic [DW-1:0] r1_req_wdata, r1_rsp_data;
  logic [AW-1:0] mem_address0;
  logic          mem_ce0, mem_we0;
  logic [DW-1:0] mem_d0, mem_q0;

  // Instance B (RdLatency=3)
  logic          b_r0_req_valid, b_r0_req_ready, b_r0_req_we, b_r0_rsp_valid;
  logic [AW-1:0] b_r0_req_addr;
  logic [DW-1:0] b_r0_req_wdata, b_r0_rsp_data;
  logic          b_r1_req_valid, b_r1_req_ready, b_r1_req_we, b_r1_rsp_valid;
  logic [AW-1:0] b_r1_req_addr;
  logic [DW-1:0] b_r1_req_wdata, b_r1_rsp_data;
  logic [AW-1:0] b_mem_address0;
  logic          b_mem_ce0, b_mem_we0;
  logic [DW-1:0] b_mem_d0, b_mem_q0;

  knn_local_mem_arbiter #(.DataWidth(DW), .AddressWidth(AW), .RdLatency(1)) dut (
    .clk(clk), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_we(r0_req_we),
    .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_we(r1_req_we),
    .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data),
    .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
    .mem_d0(mem_d0), .mem_q0(mem_q0)
  );

  knn_local_mem_arbiter #(.DataWidth(DW), .AddressWidth(AW), .RdLatency(3)) dut3 (
    .clk(clk), .reset(reset),
    .r0_req_valid(b_r0_req_valid), .r0_req_ready(b_r0_req_ready), .r0_req_we(b_r0_req_we),
    .r0_req_addr(b_r0_req_addr), .r0_req_wdata(b_r0_req_wdata),
    .r0_rsp_valid(b_r0_rsp_valid), .r0_rsp_data(b_r0_rsp_data),
    .r1_req_valid(b_r1_req_valid), .r1_req_ready(b_r1_req_ready), .r1_req_we(b_r1_req_we),
    .r1_req_addr(b_r1_req_addr), .r1_req_wdata(b_r1_req_wdata),
    .r1_rsp_valid(b_r1_rsp_valid), .r1_rsp_data(b_r1_rsp_data),
    .mem_address0(b_mem_address0), .mem_ce0(b_mem_ce0), .mem_we0(b_mem_we0),
    .mem_d0(b_mem_d0), .mem_q0(b_mem_q0)
  );

  // Behavioural buffers: A has one read stage, B has three.
  logic [DW-1:0] mem_a [2**AW];
  logic [DW-1:0] q_a;
  always @(posedge clk) begin
    if (mem_ce0) begin
      if (mem_we0) mem_a[mem_address0] <= mem_d0;
      else         q_a <= mem_a[mem_address0];
    end
  end
  assign mem_q0 = q_a;

  logic [DW-1:0] mem_b [2**AW];
  logic [DW-1:0] qb1, qb2, qb3;
  always @(posedge clk) begin
    if (b_mem_ce0 && b_mem_we0)  mem_b[b_mem_address0] <= b_mem_d0;
    if (b_mem_ce0 && !b_mem_we0) qb1 <= mem_b[b_mem_address0];
    qb2 <= qb1;
    qb3 <= qb2;
  end
  assign b_mem_q0 = qb3;

  task automatic idle_all();
    r0_req_valid = 0; r0_req_we = 0; r0_req_addr = '0; r0_req_wdata = '0;
    r1_req_valid = 0; r1_req_we = 0; r1_req_addr = '0; r1_req_wdata = '0;
    b_r0_req_valid = 0; b_r0_req_we = 0; b_r0_req_addr = '0; b_r0_req_wdata = '0;
    b_r1_req_valid = 0; b_r1_req_we = 0; b_r1_req_addr = '0; b_r1_req_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b0;
    @(negedge clk);
    r0_req_valid = 1;
    r1_req_valid = 1;
    #1;
    total++;
    if (r0_req_ready !== 1'b0 || r1_req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b%b want 00", r0_req_ready, r1_req_ready);
    end
    total++;
    if (mem_ce0 !== 1'b0 || mem_we0 !== 1'b0 || mem_address0 !== '0 || mem_d0 !== '0) begin
      bad++; $display("FAIL reset_mem: ce=%b we=%b addr=%0d want 0 0 0", mem_ce0, mem_we0, mem_address0);
    end
    total++;
    if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rsp: got %b%b want 00", r0_rsp_valid, r1_rsp_valid);
    end
    @(negedge clk);
    idle_all();
    reset = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_raw();
    logic [DW-1:0] pat;
    pat = {32{8'hA5}};
    r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 11'd5; r0_req_wdata = pat;
    #1;
    total++;
    if (r0_req_ready !== 1'b1) begin bad++; $display("FAIL raw_wr_ready: got %b want 1", r0_req_ready); end
    @(negedge clk);
    r0_req_we = 0; r0_req_wdata = '0;
    #1;
    total++;
    if (r0_req_ready !== 1'b1) begin bad++; $display("FAIL raw_rd_ready: got %b want 1", r0_req_ready); end
    total++;
    if (mem_ce0 !== 1'b1 || mem_we0 !== 1'b1 || mem_address0 !== 11'd5 || mem_d0 !== pat) begin
      bad++; $display("FAIL raw_wr_cmd: ce=%b we=%b addr=%0d want 1 1 5", mem_ce0, mem_we0, mem_address0);
    end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      idle_all();
      #1;
      total++;
      if (r0_rsp_valid !== (c == 3)) begin
        bad++; $display("FAIL raw_rsp_valid c%0d: got %b want %b", c, r0_rsp_valid, (c == 3));
      end
      total++;
      if (r1_rsp_valid !== 1'b0) begin
        bad++; $display("FAIL raw_r1_quiet c%0d: got %b want 0", c, r1_rsp_valid);
      end
      if (c == 2) begin
        total++;
        if (mem_ce0 !== 1'b1 || mem_we0 !== 1'b0) begin
          bad++; $display("FAIL raw_rd_cmd: ce=%b we=%b want 1 0", mem_ce0, mem_we0);
        end
      end
      if (c == 3) begin
        total++;
        if (r0_rsp_data !== pat) begin
          bad++; $display("FAIL raw_rsp_data: got %h want %h", r0_rsp_data, pat);
        end
      end
    end
    @(negedge clk);
    $display("test_raw done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      r1_req_valid = 1; r1_req_we = 1; r1_req_addr = AW'(i); r1_req_wdata = DW'(i);
      #1;
      total++;
      if (r1_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_wr_ready %0d: got %b want 1", i, r1_req_ready); end
      @(negedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        r1_req_valid = 1; r1_req_we = 0; r1_req_addr = AW'(c); r1_req_wdata = '0;
      end else begin
        idle_all();
      end
      #1;
      if (c < 8) begin
        total++;
        if (r1_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_rd_ready c%0d: got %b want 1", c, r1_req_ready); end
      end
      total++;
      if (r1_rsp_valid !== (c >= 2) || r0_rsp_valid !== 1'b0) begin
        bad++; $display("FAIL b2b_rsp_valid c%0d: got r1=%b r0=%b want %b 0", c, r1_rsp_valid, r0_rsp_valid, (c >= 2));
      end
      if (c >= 2) begin
        total++;
        if (r1_rsp_data !== DW'(c - 2)) begin
          bad++; $display("FAIL b2b_rsp_data c%0d: got %0d want %0d", c, r1_rsp_data, c - 2);
        end
      end
      @(negedge clk);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_contention();
    int a0 [6] = '{1, 2, 2, 3, 3, 4};
    int a1 [6] = '{4, 4, 5, 5, 6, 6};
    int ed [9] = '{0, 0, 1, 4, 2, 5, 3, 6, 0};
    logic [5:0] e_rdy0 = 6'b010101;
    logic [5:0] e_rdy1 = 6'b101010;
    logic [8:0] e_v0   = 9'b001010100;
    logic [8:0] e_v1   = 9'b010101000;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin
        r0_req_valid = 1; r0_req_we = 0; r0_req_addr = AW'(a0[c]);
        r1_req_valid = 1; r1_req_we = 0; r1_req_addr = AW'(a1[c]);
      end else begin
        idle_all();
      end
      #1;
      if (c < 6) begin
        total++;
        if (r0_req_ready !== e_rdy0[c] || r1_req_ready !== e_rdy1[c]) begin
          bad++; $display("FAIL rr_grant c%0d: got %b%b want %b%b", c, r0_req_ready, r1_req_ready, e_rdy0[c], e_rdy1[c]);
        end
      end
      total++;
      if (r0_rsp_valid !== e_v0[c] || r1_rsp_valid !== e_v1[c]) begin
        bad++; $display("FAIL rr_rsp_valid c%0d: got %b%b want %b%b", c, r0_rsp_valid, r1_rsp_valid, e_v0[c], e_v1[c]);
      end
      if (e_v0[c] || e_v1[c]) begin
        total++;
        if (mem_q0 !== DW'(ed[c]) || (e_v0[c] && r0_rsp_data !== DW'(ed[c])) || (e_v1[c] && r1_rsp_data !== DW'(ed[c]))) begin
          bad++; $display("FAIL rr_rsp_data c%0d: got %0d want %0d", c, mem_q0, ed[c]);
        end
      end
      @(negedge clk);
    end
    $display("test_contention done");
  endtask

  task automatic test_rdlat3();
    logic [DW-1:0] old_v, new_v;
    old_v = {8{32'h1111_1111}};
    new_v = {8{32'h2222_2222}};
    b_r0_req_valid = 1; b_r0_req_we = 1; b_r0_req_addr = 11'd10; b_r0_req_wdata = old_v;
    @(negedge clk);
    idle_all();
    @(negedge clk);
    for (int c = 0; c < 9; c++) begin
      idle_all();
      if (c == 0 || c == 2) begin
        b_r0_req_valid = 1; b_r0_req_we = 0; b_r0_req_addr = 11'd10;
      end
      if (c == 1) begin
        b_r1_req_valid = 1; b_r1_req_we = 1; b_r1_req_addr = 11'd10; b_r1_req_wdata = new_v;
      end
      #1;
      if (c < 3) begin
        total++;
        if ((b_r0_req_ready | b_r1_req_ready) !== 1'b1) begin
          bad++; $display("FAIL lat3_ready c%0d: got %b%b want a grant", c, b_r0_req_ready, b_r1_req_ready);
        end
      end
      total++;
      if (b_r0_rsp_valid !== (c == 4 || c == 6) || b_r1_rsp_valid !== 1'b0) begin
        bad++; $display("FAIL lat3_rsp_valid c%0d: got r0=%b r1=%b want %b 0", c, b_r0_rsp_valid, b_r1_rsp_valid, (c == 4 || c == 6));
      end
      if (c == 4 || c == 6) begin
        total++;
        if (b_r0_rsp_data !== (c == 4 ? old_v : new_v)) begin
          bad++; $display("FAIL lat3_rsp_data c%0d: got %h want %h", c, b_r0_rsp_data, (c == 4 ? old_v : new_v));
        end
      end
      @(negedge clk);
    end
    idle_all();
    $display("test_rdlat3 done");
  endtask

  task automatic test_reset_midflight();
    r1_req_valid = 1; r1_req_we = 0; r1_req_addr = 11'd2;
    #1;
    total++;
    if (r1_req_ready !== 1'b1) begin bad++; $display("FAIL mid_r1_ready: got %b want 1", r1_req_ready); end
    @(negedge clk);
    idle_all();
    r0_req_valid = 1; r0_req_we = 0; r0_req_addr = 11'd1;
    #1;
    total++;
    if (r0_req_ready !== 1'b1) begin bad++; $display("FAIL mid_r0_ready: got %b want 1", r0_req_ready); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (r1_rsp_valid !== 1'b0 || r0_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rsp_forced: got %b%b want 00", r0_rsp_valid, r1_rsp_valid);
    end
    total++;
    if (mem_ce0 !== 1'b0 || mem_address0 !== '0 || r0_req_ready !== 1'b0) begin
      bad++; $display("FAIL mid_cmd_clear: ce=%b addr=%0d ready=%b want 0 0 0", mem_ce0, mem_address0, r0_req_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    idle_all();
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0 || mem_ce0 !== 1'b0) begin
        bad++; $display("FAIL mid_quiet c%0d: rsp=%b%b ce=%b want 0 0 0", c, r0_rsp_valid, r1_rsp_valid, mem_ce0);
      end
      @(negedge clk);
    end
    r0_req_valid = 1; r0_req_addr = 11'd3;
    r1_req_valid = 1; r1_req_addr = 11'd4;
    #1;
    total++;
    if (r0_req_ready !== 1'b1 || r1_req_ready !== 1'b0) begin
      bad++; $display("FAIL mid_first_conflict: got %b%b want 10", r0_req_ready, r1_req_ready);
    end
    @(negedge clk);
    idle_all();
    @(negedge clk);
    $display("test_reset_midflight done");
  endtask

  initial begin
    test_reset();
    test_raw();
    test_back_to_back();
    test_contention();
    test_rdlat3();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
